pipe_ctrl_sched: RTL and testbench

Parametrised control-word pipeline and issue scheduler for the pairing datapath. It sits between the sequencer and the read/preadd/reduction/QPMM/cmul/postadd/write chain. It accepts one control word per cycle through a valid/ready handshake and delays each word to configurable stage taps. It blocks issue on read-after-write hazards against in-flight writes of the same thread, and tracks pipeline occupancy and a busy-cycle count.

---
 rtl/pipe_ctrl_sched_pkg.sv | 40 ++++
 rtl/pipe_ctrl_sched_hazard.sv | 34 +++
 rtl/pipe_ctrl_sched.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_sched_pkg.sv
// Shared types and default latency budget for the pairing-datapath control pipeline.
// The default tap indices and pipeline depth are derived from the per-unit latencies.
package pipe_ctrl_sched_pkg;

   localparam int N_THREADS = 4;
   localparam int THREAD_W  = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
   localparam int ADDR_W    = 9;
   localparam int OPCODE_W  = 27;

   localparam int LAT_READ    = 2;
   localparam int LAT_PREADD  = 1;
   localparam int LAT_UINT    = 4;
   localparam int LAT_QPMM    = 58;
   localparam int LAT_CMUL    = 1;
   localparam int LAT_POSTADD = 2;
   localparam int LAT_WRITE   = 1;

   localparam int DEF_TAP_PREADD  = LAT_READ;
   localparam int DEF_TAP_CMUL    = LAT_READ + LAT_PREADD + LAT_UINT + LAT_QPMM;
   localparam int DEF_TAP_POSTADD = DEF_TAP_CMUL + LAT_CMUL;
   localparam int DEF_PIPE_DEPTH  = DEF_TAP_POSTADD + LAT_POSTADD + LAT_WRITE;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [THREAD_W-1:0] thread;
      logic [ADDR_W-1:0]   raddr0;
      logic [ADDR_W-1:0]   raddr1;
      logic [ADDR_W-1:0]   waddr0;
      logic [ADDR_W-1:0]   waddr1;
      logic                we0;
      logic                we1;
      logic                rd0;
      logic                rd1;
   } ctrl_word_t;

   function automatic ctrl_word_t gate_word(input logic vld, input ctrl_word_t w);
      return vld ? w : '0;
   endfunction

endpackage

// File: rtl/pipe_ctrl_sched_hazard.sv
// pipe_hazard_check: flags a read that hits a pending same-thread write anywhere in
// the delay line. Purely combinational; one comparator pair per stage.
module pipe_hazard_check
   import pipe_ctrl_sched_pkg::*;
#(
   parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
   input  logic                                 rd0_i,
   input  logic                                 rd1_i,
   input  logic [ADDR_W-1:0]                    raddr0_i,
   input  logic [ADDR_W-1:0]                    raddr1_i,
   input  logic [THREAD_W-1:0]                  thread_i,
   input  logic [PIPE_DEPTH-1:0]                stg_vld_i,
   input  logic [PIPE_DEPTH-1:0]                stg_we0_i,
   input  logic [PIPE_DEPTH-1:0]                stg_we1_i,
   input  logic [PIPE_DEPTH-1:0][THREAD_W-1:0]  stg_thread_i,
   input  logic [PIPE_DEPTH-1:0][ADDR_W-1:0]    stg_waddr0_i,
   input  logic [PIPE_DEPTH-1:0][ADDR_W-1:0]    stg_waddr1_i,
   output logic                                 hazard_o
);

   logic [PIPE_DEPTH-1:0] hit;

   for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stg
      logic same_thr, hit0, hit1;
      assign same_thr = stg_vld_i[i] & (stg_thread_i[i] == thread_i);
      assign hit0     = rd0_i & stg_we0_i[i] & (stg_waddr0_i[i] == raddr0_i);
      assign hit1     = rd1_i & stg_we1_i[i] & (stg_waddr1_i[i] == raddr1_i);
      assign hit[i]   = same_thr & (hit0 | hit1);
   end

   assign hazard_o = |hit;

endmodule

// File: rtl/pipe_ctrl_sched.sv
// pipe_ctrl_sched: control-word delay line with stage taps, occupancy and busy counters.
// Define PIPE_CTRL_HAZARD_EN to stall issue on same-thread read-after-write hazards.
module pipe_ctrl_sched
   import pipe_ctrl_sched_pkg::*;
#(
   parameter int PIPE_DEPTH  = DEF_PIPE_DEPTH,
   parameter int TAP_PREADD  = DEF_TAP_PREADD,
   parameter int TAP_CMUL    = DEF_TAP_CMUL,
   parameter int TAP_POSTADD = DEF_TAP_POSTADD,
   parameter int CNT_W       = 24
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              flush,
   input  logic                              busy,
   input  logic                              issue_valid,
   output logic                              issue_ready,
   input  ctrl_word_t                        issue_word,
   output ctrl_word_t                        tap_preadd,
   output ctrl_word_t                        tap_cmul,
   output ctrl_word_t                        tap_postadd,
   output ctrl_word_t                        tap_postadd2,
   output ctrl_word_t                        tap_write,
   output logic                              me0,
   output logic                              me1,
   output logic [$clog2(PIPE_DEPTH+1)-1:0]   inflight,
   output logic                              drained,
   output logic [CNT_W-1:0]                  cycle_cnt
);

   localparam int INF_W = $clog2(PIPE_DEPTH + 1);

   logic [PIPE_DEPTH-1:0]        vld_pipe_q, vld_pipe_d;
   ctrl_word_t [PIPE_DEPTH-1:0]  sr_word_q, sr_word_d;
   logic [INF_W-1:0]             inflight_q, inflight_d;
   logic [CNT_W-1:0]             cycle_cnt_q, cycle_cnt_d;
   logic                         hazard, accept, retire;

`ifdef PIPE_CTRL_HAZARD_EN
   logic [PIPE_DEPTH-1:0]                stg_we0, stg_we1;
   logic [PIPE_DEPTH-1:0][THREAD_W-1:0]  stg_thread;
   logic [PIPE_DEPTH-1:0][ADDR_W-1:0]    stg_waddr0, stg_waddr1;

   for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_fld
      assign stg_we0[i]    = sr_word_q[i].we0;
      assign stg_we1[i]    = sr_word_q[i].we1;
      assign stg_thread[i] = sr_word_q[i].thread;
      assign stg_waddr0[i] = sr_word_q[i].waddr0;
      assign stg_waddr1[i] = sr_word_q[i].waddr1;
   end

   pipe_hazard_check #(.PIPE_DEPTH(PIPE_DEPTH)) u_hazard (
      .rd0_i        (issue_word.rd0),
      .rd1_i        (issue_word.rd1),
      .raddr0_i     (issue_word.raddr0),
      .raddr1_i     (issue_word.raddr1),
      .thread_i     (issue_word.thread),
      .stg_vld_i    (vld_pipe_q),
      .stg_we0_i    (stg_we0),
      .stg_we1_i    (stg_we1),
      .stg_thread_i (stg_thread),
      .stg_waddr0_i (stg_waddr0),
      .stg_waddr1_i (stg_waddr1),
      .hazard_o     (hazard)
   );
`else
   assign hazard = 1'b0;
`endif

   // Ready depends only on flush and the in-flight writes, never on issue_valid.
   assign issue_ready = !flush && !hazard;
   assign accept      = issue_valid && issue_ready;
   assign retire      = vld_pipe_q[PIPE_DEPTH-1];

   always_comb begin
      vld_pipe_d  = {vld_pipe_q[PIPE_DEPTH-2:0], accept};
      sr_word_d   = {sr_word_q[PIPE_DEPTH-2:0], gate_word(accept, issue_word)};
      inflight_d  = inflight_q;
      cycle_cnt_d = cycle_cnt_q;
      case ({accept, retire})
         2'b10:   inflight_d = inflight_q + INF_W'(1);
         2'b01:   inflight_d = inflight_q - INF_W'(1);
         default: inflight_d = inflight_q;
      endcase
      if (busy) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (flush) begin
         vld_pipe_d  = '0;
         sr_word_d   = '0;
         inflight_d  = '0;
         cycle_cnt_d = busy ? cycle_cnt_q : '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_pipe_q  <= '0;
         sr_word_q   <= '0;
         inflight_q  <= '0;
         cycle_cnt_q <= '0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         sr_word_q   <= sr_word_d;
         inflight_q  <= inflight_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign tap_preadd   = gate_word(vld_pipe_q[TAP_PREADD],    sr_word_q[TAP_PREADD]);
   assign tap_cmul     = gate_word(vld_pipe_q[TAP_CMUL],      sr_word_q[TAP_CMUL]);
   assign tap_postadd  = gate_word(vld_pipe_q[TAP_POSTADD],   sr_word_q[TAP_POSTADD]);
   assign tap_postadd2 = gate_word(vld_pipe_q[TAP_POSTADD+1], sr_word_q[TAP_POSTADD+1]);
   assign tap_write    = gate_word(vld_pipe_q[PIPE_DEPTH-1],  sr_word_q[PIPE_DEPTH-1]);

   // Only thread 0 owns the RAM write ports.
   assign me0 = retire && sr_word_q[PIPE_DEPTH-1].we0 && (sr_word_q[PIPE_DEPTH-1].thread == '0);
   assign me1 = retire && sr_word_q[PIPE_DEPTH-1].we1 && (sr_word_q[PIPE_DEPTH-1].thread == '0);

   assign inflight  = inflight_q;
   assign drained   = (inflight_q == '0);
   assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_sched.sv
// Bench for pipe_ctrl_sched: directed plus random issue traffic checked every cycle
// against a history of accepted words indexed by acceptance cycle.
module tb_pipe_ctrl_sched;
   import pipe_ctrl_sched_pkg::*;

   localparam int PD   = DEF_PIPE_DEPTH;
   localparam int TP   = DEF_TAP_PREADD;
   localparam int TC   = DEF_TAP_CMUL;
   localparam int TPA  = DEF_TAP_POSTADD;
   localparam int CW   = 24;
   localparam int IW   = $clog2(PD + 1);
   localparam int MAXC = 4096;

   logic       clk = 1'b0;
   logic       rstn = 1'b0, flush = 1'b0, busy = 1'b0, issue_valid = 1'b0;
   ctrl_word_t issue_word = '0;
   logic       issue_ready, me0, me1, drained;
   ctrl_word_t tap_preadd, tap_cmul, tap_postadd, tap_postadd2, tap_write;
   logic [IW-1:0] inflight;
   logic [CW-1:0] cycle_cnt;

   pipe_ctrl_sched #(.CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .busy(busy),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_word(issue_word),
      .tap_preadd(tap_preadd), .tap_cmul(tap_cmul), .tap_postadd(tap_postadd),
      .tap_postadd2(tap_postadd2), .tap_write(tap_write),
      .me0(me0), .me1(me1), .inflight(inflight), .drained(drained), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: which cycle accepted which word, and the last cycle that killed the pipe.
   int            cyc = 0, kill = -1, n_assert = 0, n_fail = 0;
   bit            acc_v [MAXC];
   ctrl_word_t    acc_w [MAXC];
   bit            last_acc = 1'b0;
   logic [CW-1:0] mcnt = '0;

   function automatic bit alive(int a, int c);
      return (a >= 0) && (a < c) && (a > kill) && acc_v[a];
   endfunction

   // Word accepted at a sits on stage k during cycle a+1+k.
   function automatic ctrl_word_t exp_tap(int c, int k);
      int a = c - 1 - k;
      return alive(a, c) ? acc_w[a] : '0;
   endfunction

   function automatic int exp_infl(int c);
      int n = 0;
      for (int a = c - PD; a < c; a++) if (alive(a, c)) n++;
      return n;
   endfunction

   function automatic bit exp_haz(int c, ctrl_word_t w);
      bit h = 1'b0;
`ifdef PIPE_CTRL_HAZARD_EN
      for (int a = c - PD; a < c; a++) begin
         if (alive(a, c) && acc_w[a].thread == w.thread &&
             ((w.rd0 && acc_w[a].we0 && w.raddr0 == acc_w[a].waddr0) ||
              (w.rd1 && acc_w[a].we1 && w.raddr1 == acc_w[a].waddr1)))
            h = 1'b1;
      end
`else
      if (c < 0) h = w.rd0;
`endif
      return h;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      int c;
      bit exp_rdy;
      ctrl_word_t ww;
      c = cyc;
      if (c >= MAXC) begin
         $display("FAIL cycle_budget cyc=%0d observed=overrun expected=<%0d", c, MAXC);
         $fatal(1, "cycle budget exceeded");
      end
      if (!rstn) begin kill = c; mcnt = '0; end
      @(negedge clk);
      exp_rdy = !flush && !exp_haz(c, issue_word);
      ww = exp_tap(c, PD - 1);
      chk("issue_ready",  128'(issue_ready),  128'(exp_rdy));
      chk("tap_preadd",   128'(tap_preadd),   128'(exp_tap(c, TP)));
      chk("tap_cmul",     128'(tap_cmul),     128'(exp_tap(c, TC)));
      chk("tap_postadd",  128'(tap_postadd),  128'(exp_tap(c, TPA)));
      chk("tap_postadd2", 128'(tap_postadd2), 128'(exp_tap(c, TPA + 1)));
      chk("tap_write",    128'(tap_write),    128'(ww));
      chk("me0",          128'(me0),          128'(ww.we0 && ww.thread == '0));
      chk("me1",          128'(me1),          128'(ww.we1 && ww.thread == '0));
      chk("inflight",     128'(inflight),     128'(exp_infl(c)));
      chk("drained",      128'(drained),      128'(exp_infl(c) == 0));
      chk("cycle_cnt",    128'(cycle_cnt),    128'(mcnt));
      last_acc = rstn && issue_valid && exp_rdy;
      acc_v[c] = last_acc;
      acc_w[c] = issue_word;
      if (rstn) begin
         if (flush) begin
            kill = c;
            if (!busy) mcnt = '0;
         end else if (busy) mcnt = mcnt + 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      issue_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Offer one word and hold it until accepted, with a bounded wait.
   task automatic issue(input ctrl_word_t w);
      int n = 0;
      issue_valid = 1'b1;
      issue_word  = w;
      do begin step(); n++; end while (!last_acc && n < 200);
      n_assert++;
      assert (last_acc) else begin
         n_fail++;
         $error("FAIL issue_timeout cyc=%0d observed=no_accept expected=accept", cyc);
      end
      issue_valid = 1'b0;
   endtask

   function automatic ctrl_word_t mkw(input int thr, input bit we0, input int wa0,
                                      input bit rd0, input int ra0);
      ctrl_word_t w = '0;
      w.opcode = OPCODE_W'($urandom) | 1'b1;
      w.thread = THREAD_W'(thr);
      w.we0 = we0;  w.waddr0 = ADDR_W'(wa0);
      w.rd0 = rd0;  w.raddr0 = ADDR_W'(ra0);
      return w;
   endfunction

   function automatic ctrl_word_t rnd_word(input bit allow_rd);
      ctrl_word_t w;
      w.opcode = OPCODE_W'($urandom);
      w.thread = THREAD_W'($urandom_range(0, N_THREADS - 1));
      w.raddr0 = ADDR_W'($urandom_range(0, 7));
      w.raddr1 = ADDR_W'($urandom_range(0, 7));
      w.waddr0 = ADDR_W'($urandom_range(0, 7));
      w.waddr1 = ADDR_W'($urandom_range(0, 7));
      w.we0 = 1'($urandom);  w.we1 = 1'($urandom);
      w.rd0 = allow_rd & 1'($urandom);  w.rd1 = allow_rd & 1'($urandom);
      return w;
   endfunction

   task automatic rand_run(input int n);
      bit pend = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!pend) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_word  = rnd_word(1'b1);
         end
         flush = ($urandom_range(0, 39) == 0);
         busy  = ($urandom_range(0, 7) != 0);
         step();
         pend = issue_valid && !last_acc;
      end
      issue_valid = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      idle(3);
      rstn = 1'b1;
      busy = 1'b1;
      idle(2);
      // Single thread-0 write traced to the write stage and out.
      issue(mkw(0, 1'b1, 5, 1'b0, 0));
      idle(PD + 2);
      // Write then dependent read on the same thread.
      issue(mkw(0, 1'b1, 5, 1'b0, 0));
      issue(mkw(0, 1'b0, 0, 1'b1, 5));
      idle(PD + 2);
      // Thread-0 write, thread-1 read of the same address, thread-1 write.
      issue(mkw(0, 1'b1, 5, 1'b0, 0));
      issue(mkw(1, 1'b0, 0, 1'b1, 5));
      issue(mkw(1, 1'b1, 5, 1'b0, 0));
      idle(PD + 2);
      // 40-word burst with a flush in the middle, first holding then clearing the counter.
      for (int i = 0; i < 40; i++) begin
         if (i == 20) begin
            issue_valid = 1'b1;
            issue_word  = rnd_word(1'b0);
            flush = 1'b1;  busy = 1'b1;  step();
            busy = 1'b0;  step();
            flush = 1'b0;  busy = 1'b1;
         end
         issue(rnd_word(1'b0));
      end
      idle(PD + 2);
      // Random traffic, a one-cycle reset mid-stream, then more traffic and a drain.
      rand_run(150);
      issue_valid = 1'b1;
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      rand_run(150);
      busy = 1'b0;
      idle(PD + 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
